ball_motion: RTL and testbench

Frame-rate object-motion engine that drives the position of a square ball for the pixel generator. On each rising edge of the frame tick from the sync stage it advances the ball by a fixed step, reflects it off the screen edges and flags each bounce. It also registers a per-pixel "ball here" flag from the scan coordinates, so the pixel generator only has to colour it.

---
 rtl/ball_motion.sv | 93 +++++++++
 tb/tb_ball_motion.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: frame-rate ball position engine with wall reflection and per-pixel ball flag
// Ports: clk/rst (async active-low) | ref_tick frame tick, go/stop run control, pix_x/pix_y scan position
//        ball_x/ball_y top-left corner, dir_x/dir_y heading (1 = right/down), bounce reflect pulse,
//        ball_on registered pixel-inside-ball flag, running high while moving
module ball_motion #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BALL_SIZE = 8,
  parameter int SPEED     = 2,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 236
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ref_tick,
  input  logic       go,
  input  logic       stop,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       ball_on,
  output logic       running
);
  localparam logic [10:0] XMAX = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] YMAX = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] STEP = 11'(SPEED);
  localparam logic [10:0] SIZE = 11'(BALL_SIZE);
  typedef enum logic {HOLD, RUN} state_t;
  state_t      state;
  logic        tick_q, upd, hit_r, hit_l, hit_d, hit_u, refl_x, refl_y, on_w;
  logic [10:0] x_w, y_w, x_up, y_up, px_w, py_w;
  logic [9:0]  x_nxt, y_nxt;
  // 11-bit arithmetic keeps the wall comparisons from wrapping
  assign x_w  = {1'b0, ball_x};
  assign y_w  = {1'b0, ball_y};
  assign px_w = {1'b0, pix_x};
  assign py_w = {1'b0, pix_y};
  assign x_up = x_w + STEP;
  assign y_up = y_w + STEP;
  assign upd  = ref_tick & ~tick_q;
  always_comb begin
    hit_r  = x_up >= XMAX;
    hit_l  = x_w <= STEP;
    hit_d  = y_up >= YMAX;
    hit_u  = y_w <= STEP;
    refl_x = dir_x ? hit_r : hit_l;
    refl_y = dir_y ? hit_d : hit_u;
    x_nxt  = dir_x ? (hit_r ? XMAX[9:0] : x_up[9:0]) : (hit_l ? 10'd0 : ball_x - STEP[9:0]);
    y_nxt  = dir_y ? (hit_d ? YMAX[9:0] : y_up[9:0]) : (hit_u ? 10'd0 : ball_y - STEP[9:0]);
    on_w   = (px_w >= x_w) & (px_w < x_w + SIZE) & (py_w >= y_w) & (py_w < y_w + SIZE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HOLD;
      tick_q  <= 1'b0;
      ball_x  <= 10'(X_INIT);
      ball_y  <= 10'(Y_INIT);
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      bounce  <= 1'b0;
      ball_on <= 1'b0;
      running <= 1'b0;
    end else begin
      tick_q  <= ref_tick;
      ball_on <= on_w;
      bounce  <= 1'b0;
      if (state == HOLD) begin
        if (go) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (stop) begin
        // stop wins over a coincident tick edge and re-serves the ball
        state   <= HOLD;
        running <= 1'b0;
        ball_x  <= 10'(X_INIT);
        ball_y  <= 10'(Y_INIT);
        dir_x   <= 1'b1;
        dir_y   <= 1'b1;
      end else if (upd) begin
        ball_x <= x_nxt;
        ball_y <= y_nxt;
        dir_x  <= refl_x ? ~dir_x : dir_x;
        dir_y  <= refl_y ? ~dir_y : dir_y;
        bounce <= refl_x | refl_y;
      end
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: checks ball_motion against a cycle-level reference model plus directed sequences
module tb_ball_motion;
  localparam int XM = 632, YM = 472, S = 2, BS = 8, X0 = 100, Y0 = 50;
  logic clk = 0, rst = 0, ref_tick = 0, go = 0, stop = 0;
  logic [9:0] pix_x = 0, pix_y = 0;
  logic [9:0] ball_x, ball_y, c_x, c_y;
  logic dir_x, dir_y, bounce, ball_on, running;
  logic c_dx, c_dy, c_b, c_on, c_run;
  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  int m_x = X0, m_y = Y0, m_dx = 1, m_dy = 1;
  bit m_b = 0, m_on = 0, m_run = 0, m_prev = 0;
  typedef struct { int px; int py; bit on; } pv_t;
  pv_t tbl[6];
  always #5 clk = ~clk;
  ball_motion #(.X_INIT(X0), .Y_INIT(Y0)) dut (
    .clk(clk), .rst(rst), .ref_tick(ref_tick), .go(go), .stop(stop),
    .pix_x(pix_x), .pix_y(pix_y), .ball_x(ball_x), .ball_y(ball_y),
    .dir_x(dir_x), .dir_y(dir_y), .bounce(bounce), .ball_on(ball_on), .running(running));
  ball_motion #(.X_INIT(631), .Y_INIT(471)) dut_c (
    .clk(clk), .rst(rst), .ref_tick(ref_tick), .go(go), .stop(stop),
    .pix_x(pix_x), .pix_y(pix_y), .ball_x(c_x), .ball_y(c_y),
    .dir_x(c_dx), .dir_y(c_dy), .bounce(c_b), .ball_on(c_on), .running(c_run));
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit in_ball(input int px, input int py, input int bx, input int by);
    return px >= bx && px < bx + BS && py >= by && py < by + BS;
  endfunction
  function automatic int move(input int p, inout int d, input int lim, inout bit b);
    int t;
    t = p + d * S;
    if (t >= lim) begin t = lim; d = -1; b = 1; end
    else if (t <= 0) begin t = 0; d = 1; b = 1; end
    return t;
  endfunction
  task automatic model_step();
    if (!rst) begin
      m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1; m_b = 0; m_on = 0; m_run = 0; m_prev = 0;
    end else begin
      m_on = in_ball(int'(pix_x), int'(pix_y), m_x, m_y);
      m_b = 0;
      if (m_run) begin
        if (stop) begin
          m_run = 0; m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1;
        end else if (ref_tick && !m_prev) begin
          m_x = move(m_x, m_dx, XM, m_b);
          m_y = move(m_y, m_dy, YM, m_b);
        end
      end else if (go) m_run = 1;
      m_prev = ref_tick;
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ball_x", ball_x, m_x);
      chk("ball_y", ball_y, m_y);
      chk("dir_x", dir_x, m_dx > 0);
      chk("dir_y", dir_y, m_dy > 0);
      chk("bounce", bounce, m_b);
      chk("ball_on", ball_on, m_on);
      chk("running", running, m_run);
    end
  end
  task automatic tick1();
    ref_tick = 1;
    @(negedge clk);
    ref_tick = 0;
    @(negedge clk);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_x"}, ball_x, X0);
    chk({nm, "_y"}, ball_y, Y0);
    chk({nm, "_dir"}, {dir_x, dir_y}, 3);
    chk({nm, "_bounce"}, bounce, 0);
    chk({nm, "_on"}, ball_on, 0);
    chk({nm, "_run"}, running, 0);
  endtask
  initial begin
    bit seen;
    int n;
    tbl[0] = '{100, 50, 1}; tbl[1] = '{107, 57, 1}; tbl[2] = '{108, 50, 0};
    tbl[3] = '{99, 57, 0};  tbl[4] = '{100, 58, 0}; tbl[5] = '{100, 49, 0};
    repeat (2) @(negedge clk);
    chk_reset("reset");
    chk_en = 1;
    #2 rst = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      pix_x = 10'(tbl[i].px);
      pix_y = 10'(tbl[i].py);
      @(negedge clk);
      chk("pix_tbl", ball_on, tbl[i].on);
    end
    pix_x = 0; pix_y = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    chk("go_running", running, 1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      ref_tick = 1;
      @(negedge clk); seen |= bounce;
      ref_tick = 0;
      @(negedge clk); seen |= bounce;
    end
    chk("free_x", ball_x, 106);
    chk("free_y", ball_y, 56);
    chk("free_nobounce", seen, 0);
    ref_tick = 1;
    repeat (5) @(negedge clk);
    ref_tick = 0;
    @(negedge clk);
    chk("long_tick_x", ball_x, 108);
    chk("long_tick_y", ball_y, 58);
    n = 0;
    while (!(m_x == 630 && m_dx == 1) && n < 2000) begin
      tick1();
      n++;
    end
    chk("reach_630", ball_x, 630);
    ref_tick = 1;
    @(negedge clk);
    chk("wall_x", ball_x, 632);
    chk("wall_dir", dir_x, 0);
    chk("wall_bounce", bounce, 1);
    ref_tick = 0;
    @(negedge clk);
    chk("wall_bounce_end", bounce, 0);
    tick1();
    chk("wall_back_x", ball_x, 630);
    stop = 1; ref_tick = 1;
    @(negedge clk);
    chk("stop_x", ball_x, X0);
    chk("stop_y", ball_y, Y0);
    chk("stop_bounce", bounce, 0);
    chk("stop_run", running, 0);
    stop = 0; ref_tick = 0;
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    #2 rst = 1;
    go = 1;
    @(negedge clk);
    go = 0;
    ref_tick = 1;
    @(negedge clk);
    chk("corner_x", c_x, 632);
    chk("corner_y", c_y, 472);
    chk("corner_dir", {c_dx, c_dy}, 0);
    chk("corner_bounce", c_b, 1);
    ref_tick = 0;
    @(negedge clk);
    chk("corner_bounce_end", c_b, 0);
    for (int i = 0; i < 4000; i++) begin
      ref_tick = $urandom_range(0, 2) == 0;
      go = $urandom_range(0, 9) == 0;
      stop = $urandom_range(0, 299) == 0;
      pix_x = 10'(m_x + int'($urandom_range(0, 11)) - 2);
      pix_y = 10'(m_y + int'($urandom_range(0, 11)) - 2);
      @(negedge clk);
    end
    ref_tick = 0; stop = 0; go = 1;
    @(negedge clk);
    go = 0;
    repeat (20) tick1();
    #2 rst = 0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    ref_tick = 1;
    @(negedge clk);
    #2 rst = 1;
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (3) @(negedge clk);
    chk("held_tick_x", ball_x, X0);
    ref_tick = 0;
    @(negedge clk);
    ref_tick = 1;
    @(negedge clk);
    chk("new_edge_x", ball_x, X0 + S);
    ref_tick = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
